vdraw_sprite: RTL

Sprite draw engine on the write side of the video RAM. It reads CHIP-8/SCHIP sprite bytes from main memory and XORs them into VRAM with a pixel-serial read-modify-write, then reports collision. The display driver scans the same VRAM from the read side. This block sits between the CPU's DRW execution unit and the VRAM write port.

---
 rtl/vdrive_pkg.sv | 34 +++
 rtl/vdraw_clip.sv | 42 ++++
 rtl/vdraw_sprite.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vdrive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdrive_pkg
// Description : Shared types and constants for the video drive / sprite draw
//               blocks: draw FSM state encoding, plane geometry, byte cost.
// Revision    : 1.0 - initial release
// ============================================================================
package vdrive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_FWAIT  = 3'd2,
        ST_PIX_RD = 3'd3,
        ST_PIX_WR = 3'd4,
        ST_DONE   = 3'd5
    } draw_state_e;

    localparam int LORES_W     = 64;
    localparam int LORES_H     = 32;
    localparam int HIRES_W     = 128;
    localparam int HIRES_H     = 64;
    localparam int BYTE_CYCLES = 18;

    // Total sprite byte count; rows==0 selects the 16-row form (16x16 in hires).
    function automatic logic [5:0] sprite_bytes(input logic hires, input logic [3:0] rows);
        if (rows != 4'd0) begin
            return {2'b00, rows};
        end
        return hires ? 6'd32 : 6'd16;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdraw_clip.sv
`default_nettype none
// ============================================================================
// Module      : vdraw_clip
// Description : Wraps the sprite origin into the active plane, adds the pixel
//               offset and flags pixels that fall past the right/bottom edge.
// Revision    : 1.0 - initial release
// ============================================================================
module vdraw_clip
    import vdrive_pkg::*;
(
    input  logic       hires_i,
    input  logic [6:0] org_x_i,
    input  logic [5:0] org_y_i,
    input  logic [3:0] dx_i,
    input  logic [3:0] dy_i,
    output logic [6:0] hpos_o,
    output logic [5:0] vpos_o,
    output logic       visible_o
);

    logic [6:0] w_org_x;
    logic [5:0] w_org_y;
    logic [7:0] w_sum_x;
    logic [6:0] w_sum_y;
    logic [7:0] w_width;
    logic [6:0] w_height;

    always_comb begin
        // Origin wraps; the offset added afterwards does not, so it can clip.
        w_org_x   = hires_i ? org_x_i : {1'b0, org_x_i[5:0]};
        w_org_y   = hires_i ? org_y_i : {1'b0, org_y_i[4:0]};
        w_width   = hires_i ? 8'(HIRES_W) : 8'(LORES_W);
        w_height  = hires_i ? 7'(HIRES_H) : 7'(LORES_H);
        w_sum_x   = {1'b0, w_org_x} + {4'b0000, dx_i};
        w_sum_y   = {1'b0, w_org_y} + {3'b000, dy_i};
        hpos_o    = w_sum_x[6:0];
        vpos_o    = w_sum_y[5:0];
        visible_o = (w_sum_x < w_width) && (w_sum_y < w_height);
    end

endmodule
`default_nettype wire

// File: rtl/vdraw_sprite.sv
`default_nettype none
// ============================================================================
// Module      : vdraw_sprite
// Description : CHIP-8/SCHIP sprite draw engine: fetches sprite bytes and XORs
//               them pixel-serially into VRAM, reporting collision.
// Revision    : 1.0 - initial release
// ============================================================================
module vdraw_sprite
    import vdrive_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hires,
    input  logic              start,
    input  logic [6:0]        draw_x,
    input  logic [5:0]        draw_y,
    input  logic [3:0]        rows,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [1:0]        plane_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic [6:0]        vram_hpos,
    output logic [5:0]        vram_vpos,
    input  logic [1:0]        vram_rdata,
    output logic              vram_we,
    output logic [1:0]        vram_wdata,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    draw_state_e       state_q, state_d;
    logic              hires_q;
    logic              wide_q;
    logic [6:0]        x_q;
    logic [5:0]        y_q;
    logic [1:0]        mask_q;
    logic [ADDR_W-1:0] base_q;
    logic [5:0]        nbytes_q;
    logic [5:0]        byte_q;
    logic [2:0]        bit_q;
    logic [7:0]        data_q;
    logic              coll_acc_q;
    logic              collision_q;

    logic [3:0]        w_dx;
    logic [3:0]        w_dy;
    logic              w_visible;
    logic              w_pix_bit;
    logic              w_last_bit;
    logic              w_last_byte;
    logic              w_hit;
    logic              w_coll_now;

    // In 16-wide sprites the byte index interleaves left/right halves per row.
    assign w_dx = wide_q ? {byte_q[0], bit_q} : {1'b0, bit_q};
    assign w_dy = wide_q ? byte_q[4:1] : byte_q[3:0];

    vdraw_clip u_clip (
        .hires_i   (hires_q),
        .org_x_i   (x_q),
        .org_y_i   (y_q),
        .dx_i      (w_dx),
        .dy_i      (w_dy),
        .hpos_o    (vram_hpos),
        .vpos_o    (vram_vpos),
        .visible_o (w_visible)
    );

    assign w_pix_bit   = data_q[3'd7 - bit_q];
    assign w_last_bit  = (bit_q == 3'd7);
    assign w_last_byte = (byte_q == (nbytes_q - 6'd1));
    assign w_hit       = (state_q == ST_PIX_WR) && w_pix_bit && w_visible;
    assign w_coll_now  = w_hit && ((vram_rdata & mask_q) != 2'b00);

    assign vram_we    = w_hit && (mask_q != 2'b00);
    assign vram_wdata = vram_rdata ^ mask_q;
    assign mem_addr   = base_q + ADDR_W'(byte_q);
    assign mem_rd     = (state_q == ST_FETCH);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign collision  = collision_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_FWAIT;
            ST_FWAIT:  state_d = ST_PIX_RD;
            ST_PIX_RD: state_d = ST_PIX_WR;
            ST_PIX_WR: begin
                if (!w_last_bit)      state_d = ST_PIX_RD;
                else if (w_last_byte) state_d = ST_DONE;
                else                  state_d = ST_FETCH;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hires_q     <= 1'b0;
            wide_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            mask_q      <= '0;
            base_q      <= '0;
            nbytes_q    <= '0;
            byte_q      <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            coll_acc_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hires_q     <= hires;
                        wide_q      <= hires && (rows == 4'd0);
                        x_q         <= draw_x;
                        y_q         <= draw_y;
                        mask_q      <= plane_mask;
                        base_q      <= base_addr;
                        nbytes_q    <= sprite_bytes(hires, rows);
                        byte_q      <= '0;
                        bit_q       <= '0;
                        coll_acc_q  <= 1'b0;
                        collision_q <= 1'b0;
                    end
                end
                ST_FWAIT: data_q <= mem_data;
                ST_PIX_WR: begin
                    bit_q      <= bit_q + 3'd1;
                    coll_acc_q <= coll_acc_q | w_coll_now;
                    if (w_last_bit) begin
                        byte_q <= byte_q + 6'd1;
                        if (w_last_byte) begin
                            collision_q <= coll_acc_q | w_coll_now;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
